mem_bist_ctrl: RTL and testbench
================================

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words tested.
REQ-002 SHALL have parameter SEED, default 32'hA5A5_0000, pattern base value.
REQ-003 SHALL have port Clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Start, input, 1, level-sampled request to begin a test run.
REQ-006 SHALL have port MR, output, 1, memory read enable to DataMemory.
REQ-007 SHALL have port MW, output, 1, memory write enable to DataMemory.
REQ-008 SHALL have port Addr, output, 32, byte address to DataMemory.
REQ-009 SHALL have port WD, output, 32, write data to DataMemory.
REQ-010 SHALL have port RD, input, 32, read data from DataMemory, valid in the same cycle as MR.
REQ-011 SHALL have port Busy, output, 1, high while a run is in progress.
REQ-012 SHALL have port Done, output, 1, sticky: run completed with no mismatch.
REQ-013 SHALL have port Fail, output, 1, sticky: run stopped on first mismatch.
REQ-014 SHALL have ports FailAddr, FailExp and FailGot, outputs, 32 each: byte address, expected word and read word of the first mismatch.

Function
REQ-015 SHALL implement states IDLE, W0, R0, W1, R1, DONE, FAIL, plus an 8-bit word index idx (width clog2(DEPTH)).
REQ-016 SHALL define PAT(i) = SEED + i (32-bit, modulo 2^32); W0 writes PAT(i), W1 writes ~PAT(i).
REQ-017 SHALL drive Addr = {idx, 2'b00} zero-extended to 32 bits in every state.
REQ-018 SHALL drive outputs as a Moore decode of state and idx: MW=1 only in W0/W1; MR=1 only in R0/R1; WD = pattern in W0/W1, else 0.
REQ-019 SHALL never assert MR and MW in the same cycle.
REQ-020 SHALL, in IDLE, DONE or FAIL with Start=1 at a rising edge: enter W0, set idx=0, clear Done, Fail, FailAddr, FailExp and FailGot.
REQ-021 SHALL ignore Start while in W0, R0, W1 or R1.
REQ-022 SHALL occupy one cycle per word access; idx increments each cycle and wraps from DEPTH-1 to 0 as the state advances W0->R0->W1->R1->DONE.
REQ-023 SHALL, in R0/R1, compare RD against PAT(idx) (R0) or ~PAT(idx) (R1) at the rising edge ending that cycle.
REQ-024 SHALL, on the first mismatch, enter FAIL and capture Addr, expected value and RD into FailAddr, FailExp and FailGot.
REQ-025 SHALL perform no further memory accesses once FAIL is entered.
REQ-026 SHALL take exactly 4*DEPTH cycles from Start capture to DONE on a fault-free memory.
REQ-027 SHALL assert Busy = (state in W0, R0, W1 or R1); Done = (state==DONE); Fail = (state==FAIL).
REQ-028 SHALL treat a mismatch at the last R1 word (idx=DEPTH-1) as FAIL, not DONE.

Reset
REQ-029 SHALL, while Rst_n=0, immediately force state=IDLE, idx=0 and all outputs to 0, regardless of the clock.
REQ-030 SHALL abort a run in progress on Rst_n assertion, leaving memory contents undefined and Done=Fail=0.
REQ-031 SHALL require Start to be sampled high at a rising edge after Rst_n deasserts before any access occurs.

Verification
REQ-032 SHALL verify a fault-free run: with DataMemory attached, a Start pulse gives Busy=1 for 1024 cycles, then Done=1, Fail=0, and memOut5=~(SEED+5)=32'h5A5A_FFFA.
REQ-033 SHALL verify a stuck-at-0 fault: with bit 0 of word 5 forced to 0, Fail=1 after R0 at idx=5, with FailAddr=32'h14, FailExp=32'hA5A5_0005, FailGot=32'hA5A5_0004, and MR=MW=0 afterwards.
REQ-034 SHALL verify an inverted-pass-only fault: with bit 31 of word 255 stuck at 1, FAIL occurs in R1 at the last word, with FailAddr=32'h3FC and FailExp=32'h5A5A_FF00.
REQ-035 SHALL verify reset mid-run: Rst_n=0 during W1 at idx=100 forces all outputs to 0 without waiting for a clock edge; after release, the block stays IDLE until Start.
REQ-036 SHALL verify that Start while busy is ignored: a second Start pulse at cycle 300 still gives DONE at cycle 1024, with no idx reset.
REQ-037 SHALL verify restart: Start asserted in FAIL clears Fail and all Fail* registers to 0 and begins W0 at Addr=0 with WD=32'hA5A5_0000.

Source files
------------

// File: rtl/mem_bist_ctrl_if.sv
// Memory-side bus between the BIST controller and DataMemory.
// RD is combinational: it is valid in the same cycle that MR is asserted.
interface mem_bist_ctrl_if;
  logic        MR;
  logic        MW;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output MR, MW, Addr, WD, input RD);
  modport slave  (input MR, MW, Addr, WD, output RD);
endinterface

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST controller.
// Runs four passes over DEPTH words: write PAT, read/check PAT, write ~PAT,
// read/check ~PAT. PAT(i) = SEED + i. The run stops on the first mismatch
// and records its address, expected word and read word.
module mem_bist_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter logic [31:0] SEED  = 32'hA5A5_0000
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  mem_bist_ctrl_if.master mem,
  output logic            Busy,
  output logic            Done,
  output logic            Fail,
  output logic [31:0]     FailAddr,
  output logic [31:0]     FailExp,
  output logic [31:0]     FailGot
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R0,
    W1,
    R1,
    DONE,
    FAIL
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [IW-1:0] idx;
  logic [IW-1:0] idxNext;
  logic [IW-1:0] idxInc;
  logic          lastIdx;
  logic [31:0]   addrWord;
  logic [31:0]   pat;
  logic [31:0]   expWord;
  logic          inverted;
  logic          mismatch;
  logic          capture;
  logic          clearFail;

  assign lastIdx  = (idx == LAST_IDX);
  assign idxInc   = lastIdx ? '0 : idx + 1'b1;
  assign addrWord = 32'({idx, 2'b00});
  assign pat      = SEED + 32'(idx);
  assign inverted = (state == W1) || (state == R1);
  assign expWord  = inverted ? ~pat : pat;
  assign mismatch = (mem.RD != expWord);

  // State, word index and first-failure record.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      FailAddr <= '0;
      FailExp  <= '0;
      FailGot  <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      if (clearFail) begin
        FailAddr <= '0;
        FailExp  <= '0;
        FailGot  <= '0;
      end else if (capture) begin
        FailAddr <= addrWord;
        FailExp  <= expWord;
        FailGot  <= mem.RD;
      end
    end
  end

  // Next-state sequencing through the four passes; checks happen in R0/R1.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    capture   = 1'b0;
    clearFail = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (Start) begin
          stateNext = W0;
          idxNext   = '0;
          clearFail = 1'b1;
        end
      end
      W0: begin
        idxNext = idxInc;
        if (lastIdx) stateNext = R0;
      end
      R0: begin
        if (mismatch) begin
          stateNext = FAIL;
          capture   = 1'b1;
        end else begin
          idxNext = idxInc;
          if (lastIdx) stateNext = W1;
        end
      end
      W1: begin
        idxNext = idxInc;
        if (lastIdx) stateNext = R1;
      end
      R1: begin
        // A mismatch on the final word must still land in FAIL.
        if (mismatch) begin
          stateNext = FAIL;
          capture   = 1'b1;
        end else begin
          idxNext = idxInc;
          if (lastIdx) stateNext = DONE;
        end
      end
      default: begin
        stateNext = IDLE;
        idxNext   = '0;
      end
    endcase
  end

  // Moore output decode from state and idx.
  always_comb begin
    mem.MW   = (state == W0) || (state == W1);
    mem.MR   = (state == R0) || (state == R1);
    mem.Addr = addrWord;
    mem.WD   = mem.MW ? expWord : '0;
    Busy     = (state == W0) || (state == R0) || (state == W1) || (state == R1);
    Done     = (state == DONE);
    Fail     = (state == FAIL);
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed testbench for mem_bist_ctrl with a behavioural DataMemory
// that can inject a stuck-at fault on one bit of one word.
module tb_mem_bist_ctrl;

  logic Clk = 1'b0;
  logic Rst_n;
  logic Start;
  logic Busy, Done, Fail;
  logic [31:0] FailAddr, FailExp, FailGot;

  mem_bist_ctrl_if bus ();

  mem_bist_ctrl #(
    .DEPTH(256),
    .SEED (32'hA5A5_0000)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .mem     (bus.master),
    .Busy    (Busy),
    .Done    (Done),
    .Fail    (Fail),
    .FailAddr(FailAddr),
    .FailExp (FailExp),
    .FailGot (FailGot)
  );

  always #5 Clk = ~Clk;

  // DataMemory model with optional stuck-at fault on the read path.
  logic [31:0] mem [0:255];
  logic        faultOn = 1'b0;
  logic [7:0]  faultIdx = '0;
  logic [31:0] faultMask = '0;
  logic        faultStuck1 = 1'b0;
  logic [31:0] rdWord;

  always @(posedge Clk) begin
    if (bus.MW) mem[bus.Addr[9:2]] <= bus.WD;
  end

  always_comb begin
    rdWord = mem[bus.Addr[9:2]];
    if (faultOn && (bus.Addr[9:2] == faultIdx))
      rdWord = faultStuck1 ? (rdWord | faultMask) : (rdWord & ~faultMask);
    bus.RD = rdWord;
  end

  int compared = 0;
  int mismatched = 0;
  int cnt;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic startPulse();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Counts busy cycles (bounded); optionally pulses Start at busy cycle pulseAt.
  task automatic runCount(input int pulseAt, output int n);
    n = 0;
    while (Busy && n < 2000) begin
      Start = (n == pulseAt);
      @(negedge Clk);
      n++;
    end
    Start = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0;
    Start = 1'b0;
    #3;
    checkVal("rst_busy", 32'(Busy), 32'd0);
    checkVal("rst_done", 32'(Done), 32'd0);
    checkVal("rst_fail", 32'(Fail), 32'd0);
    checkVal("rst_mr",   32'(bus.MR), 32'd0);
    checkVal("rst_mw",   32'(bus.MW), 32'd0);
    checkVal("rst_addr", bus.Addr, 32'h0);
    checkVal("rst_wd",   bus.WD, 32'h0);
    checkVal("rst_faddr", FailAddr, 32'h0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    checkVal("idle_mw", 32'(bus.MW), 32'd0);

    // Fault-free run
    startPulse();
    checkVal("w0_first_mw",   32'(bus.MW), 32'd1);
    checkVal("w0_first_mr",   32'(bus.MR), 32'd0);
    checkVal("w0_first_addr", bus.Addr, 32'h0);
    checkVal("w0_first_wd",   bus.WD, 32'hA5A5_0000);
    runCount(-1, cnt);
    checkVal("ok_cycles", 32'(cnt), 32'd1024);
    checkVal("ok_done",   32'(Done), 32'd1);
    checkVal("ok_fail",   32'(Fail), 32'd0);
    checkVal("ok_mem5",   mem[5], 32'h5A5A_FFFA);
    checkVal("ok_mr",     32'(bus.MR), 32'd0);

    // Start while busy is ignored
    startPulse();
    runCount(300, cnt);
    checkVal("busy_start_cycles", 32'(cnt), 32'd1024);
    checkVal("busy_start_done",   32'(Done), 32'd1);

    // Stuck-at-0 on bit 0 of word 5
    faultOn = 1'b1; faultIdx = 8'd5; faultMask = 32'h1; faultStuck1 = 1'b0;
    startPulse();
    checkVal("sa0_done_cleared", 32'(Done), 32'd0);
    runCount(-1, cnt);
    checkVal("sa0_cycles", 32'(cnt), 32'd262);
    checkVal("sa0_fail",   32'(Fail), 32'd1);
    checkVal("sa0_done",   32'(Done), 32'd0);
    checkVal("sa0_faddr",  FailAddr, 32'h14);
    checkVal("sa0_fexp",   FailExp, 32'hA5A5_0005);
    checkVal("sa0_fgot",   FailGot, 32'hA5A5_0004);
    repeat (3) @(negedge Clk);
    checkVal("sa0_mr_after", 32'(bus.MR), 32'd0);
    checkVal("sa0_mw_after", 32'(bus.MW), 32'd0);

    // Restart from FAIL
    faultOn = 1'b0;
    startPulse();
    checkVal("rs_fail",  32'(Fail), 32'd0);
    checkVal("rs_faddr", FailAddr, 32'h0);
    checkVal("rs_fexp",  FailExp, 32'h0);
    checkVal("rs_fgot",  FailGot, 32'h0);
    checkVal("rs_addr",  bus.Addr, 32'h0);
    checkVal("rs_wd",    bus.WD, 32'hA5A5_0000);
    checkVal("rs_mw",    32'(bus.MW), 32'd1);
    runCount(-1, cnt);
    checkVal("rs_cycles", 32'(cnt), 32'd1024);
    checkVal("rs_done",   32'(Done), 32'd1);

    // Bit 31 of word 255 stuck at 1: only the inverted pass sees it
    faultOn = 1'b1; faultIdx = 8'd255; faultMask = 32'h8000_0000; faultStuck1 = 1'b1;
    startPulse();
    runCount(-1, cnt);
    checkVal("sa1_cycles", 32'(cnt), 32'd1024);
    checkVal("sa1_fail",   32'(Fail), 32'd1);
    checkVal("sa1_done",   32'(Done), 32'd0);
    checkVal("sa1_faddr",  FailAddr, 32'h3FC);
    checkVal("sa1_fexp",   FailExp, 32'h5A5A_FF00);
    checkVal("sa1_fgot",   FailGot, 32'hDA5A_FF00);

    // Reset mid-run during W1 at idx=100
    faultOn = 1'b0;
    startPulse();
    repeat (612) @(negedge Clk);
    checkVal("w1_100_addr", bus.Addr, 32'h190);
    checkVal("w1_100_mw",   32'(bus.MW), 32'd1);
    checkVal("w1_100_wd",   bus.WD, 32'h5A5A_FF9B);
    #1 Rst_n = 1'b0;
    #1;
    checkVal("arst_busy", 32'(Busy), 32'd0);
    checkVal("arst_mw",   32'(bus.MW), 32'd0);
    checkVal("arst_addr", bus.Addr, 32'h0);
    checkVal("arst_wd",   bus.WD, 32'h0);
    checkVal("arst_done", 32'(Done), 32'd0);
    checkVal("arst_fail", 32'(Fail), 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    checkVal("post_rst_busy", 32'(Busy), 32'd0);
    checkVal("post_rst_mw",   32'(bus.MW), 32'd0);
    checkVal("post_rst_mr",   32'(bus.MR), 32'd0);
    checkVal("post_rst_done", 32'(Done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
